// File: rtl/hex_operand_assembler.sv
// hex_operand_assembler: parses ASCII hex operands from a UART byte stream into a frame of NUM_OPS operands
module hex_operand_assembler #(
   parameter int DIGITS  = 8,
   parameter int NUM_OPS = 3,
   localparam int OPW = 4 * DIGITS,
   localparam int IW  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
   localparam int DW  = $clog2(DIGITS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   input  logic                   ops_ready,
   output logic [NUM_OPS*OPW-1:0] op_bus,
   output logic                   ops_valid,
   output logic [IW-1:0]          op_idx,
   output logic                   err,
   output logic                   drop
);
   typedef enum logic [1:0] {COLLECT, FULL, ERROR} state_t;
   state_t                 state, state_n;
   logic [OPW-1:0]         work, work_n;
   logic [DW-1:0]          dcnt, dcnt_n;
   logic [IW-1:0]          idx_n;
   logic [NUM_OPS*OPW-1:0] bus_n;
   logic                   drop_n, is_num, is_dig, is_sep, is_eol;
   logic [3:0]             nib;
   // Classify the incoming byte and map hex characters to their nibble value
   always_comb begin
      is_num = rx_data >= 8'h30 && rx_data <= 8'h39;
      is_dig = is_num || (rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66);
      nib    = is_num ? rx_data[3:0] : rx_data[3:0] + 4'd9;
      is_eol = rx_data == 8'h0D || rx_data == 8'h0A;
      is_sep = is_eol || rx_data == 8'h20 || rx_data == 8'h2C;
   end
   // Next-state logic: digit accumulation, slot commit, frame handoff and error resync
   always_comb begin
      state_n = state;
      work_n  = work;
      dcnt_n  = dcnt;
      idx_n   = op_idx;
      bus_n   = op_bus;
      drop_n  = 1'b0;
      case (state)
         COLLECT: if (rx_valid) begin
            if (is_dig && dcnt != DW'(DIGITS)) begin
               work_n = {work[OPW-5:0], nib};
               dcnt_n = dcnt + 1'b1;
            end else if (is_sep) begin
               if (dcnt != '0) begin
                  bus_n[op_idx*OPW +: OPW] = work;
                  work_n  = '0;
                  dcnt_n  = '0;
                  idx_n   = (op_idx == IW'(NUM_OPS - 1)) ? '0 : op_idx + 1'b1;
                  state_n = (op_idx == IW'(NUM_OPS - 1)) ? FULL : COLLECT;
               end
            end else begin
               // overflowing digit or invalid byte: drop the partial frame, keep committed operands
               work_n  = '0;
               dcnt_n  = '0;
               idx_n   = '0;
               state_n = ERROR;
            end
         end
         FULL: begin
            drop_n  = rx_valid;
            state_n = ops_ready ? COLLECT : FULL;
         end
         ERROR: state_n = (rx_valid && is_eol) ? COLLECT : ERROR;
         default: state_n = COLLECT;
      endcase
   end
   // State and output registers; status flags are decoded from the next state so they are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         work      <= '0;
         dcnt      <= '0;
         op_idx    <= '0;
         op_bus    <= '0;
         drop      <= 1'b0;
         ops_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         work      <= work_n;
         dcnt      <= dcnt_n;
         op_idx    <= idx_n;
         op_bus    <= bus_n;
         drop      <= drop_n;
         ops_valid <= state_n == FULL;
         err       <= state_n == ERROR;
      end
   end
endmodule

// File: tb/tb_hex_operand_assembler.sv
// tb_hex_operand_assembler: table-driven directed checks of the hex operand assembler
module tb_hex_operand_assembler;
   logic        clk = 0, rst = 1, rx_valid = 0, ops_ready = 0;
   logic [7:0]  rx_data = 0;
   logic [95:0] op_bus;
   logic        ops_valid, err, drop;
   logic [1:0]  op_idx;
   int total = 0, bad = 0;

   hex_operand_assembler #(.DIGITS(8), .NUM_OPS(3)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .ops_ready(ops_ready),
      .op_bus(op_bus), .ops_valid(ops_valid), .op_idx(op_idx), .err(err), .drop(drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rdy;
      logic        ov;
      logic        er;
      logic        dr;
      logic [1:0]  idx;
      logic        cb;
      logic [95:0] bus;
   } vec_t;
   vec_t q[$];

   function automatic void add(logic [7:0] d, logic v, logic rdy, logic ov, logic er, logic dr,
                               logic [1:0] idx, logic cb, logic [95:0] bus);
      q.push_back('{v, d, rdy, ov, er, dr, idx, cb, bus});
   endfunction

   function automatic void add_str(string s, logic [1:0] idx);
      for (int i = 0; i < s.len(); i++) add(s[i], 1, 0, 0, 0, 0, idx, 0, '0);
   endfunction

   task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(logic v, logic [7:0] d, logic rdy);
      @(negedge clk);
      rx_valid = v; rx_data = d; ops_ready = rdy;
      @(posedge clk);
      #1;
      rx_valid = 0; ops_ready = 0;
   endtask

   localparam logic [95:0] F1 = {32'h7, 32'hFFFF, 32'h1234ABCD};
   localparam logic [95:0] F2 = {32'h2, 32'h1, 32'hDEADBEEF};
   localparam logic [95:0] F3 = {32'h7, 32'h6, 32'h5};
   localparam logic [95:0] F4 = {32'h7, 32'h6, 32'h9};

   initial begin
      // frame "1234ABCD 0000FFFF 7\r"
      add_str("1234ABCD", 0);
      add(8'h20, 1, 0, 0, 0, 0, 1, 1, {64'h0, 32'h1234ABCD});
      add_str("0000FFFF", 1);
      add(8'h20, 1, 0, 0, 0, 0, 2, 0, '0);
      add_str("7", 2);
      add(8'h0D, 1, 0, 1, 0, 0, 0, 1, F1);
      add(8'h00, 0, 1, 0, 0, 0, 0, 1, F1);
      // frame "deadbeef,1,2\r\n", trailing LF dropped in FULL
      add_str("deadbeef", 0);
      add(8'h2C, 1, 0, 0, 0, 0, 1, 0, '0);
      add_str("1", 1);
      add(8'h2C, 1, 0, 0, 0, 0, 2, 0, '0);
      add_str("2", 2);
      add(8'h0D, 1, 0, 1, 0, 0, 0, 1, F2);
      add(8'h0A, 1, 0, 1, 0, 1, 0, 1, F2);
      add(8'h00, 0, 0, 1, 0, 0, 0, 1, F2);
      add(8'h00, 0, 1, 0, 0, 0, 0, 1, F2);
      // overflow on ninth digit, space ignored in ERROR, LF resyncs
      add_str("12345678", 0);
      add("9", 1, 0, 0, 1, 0, 0, 1, F2);
      add(8'h20, 1, 0, 0, 1, 0, 0, 0, '0);
      add(8'h0A, 1, 0, 0, 0, 0, 0, 1, F2);
      // invalid byte, then recover with "\r5 6 7\r"
      add_str("12", 0);
      add("G", 1, 0, 0, 1, 0, 0, 1, F2);
      add(8'h0D, 1, 0, 0, 0, 0, 0, 0, '0);
      add("5", 1, 1, 0, 0, 0, 0, 0, '0);
      add(8'h20, 1, 0, 0, 0, 0, 1, 0, '0);
      add("6", 1, 0, 0, 0, 0, 1, 0, '0);
      add(8'h20, 1, 0, 0, 0, 0, 2, 0, '0);
      add("7", 1, 0, 0, 0, 0, 2, 0, '0);
      add(8'h0D, 1, 0, 1, 0, 0, 0, 1, F3);
      // ready and byte together: handshake completes, byte dropped unparsed
      add("A", 1, 1, 0, 0, 1, 0, 1, F3);
      add("9", 1, 0, 0, 0, 0, 0, 0, '0);
      add(8'h0D, 1, 0, 0, 0, 0, 1, 1, F4);
      // empty separators are ignored
      add(8'h20, 1, 0, 0, 0, 0, 1, 0, '0);
      add(8'h0D, 1, 0, 0, 0, 0, 1, 0, '0);
      add(8'h0A, 1, 0, 0, 0, 0, 1, 1, F4);
      // invalid byte mid-frame clears op_idx, keeps op_bus
      add("3", 1, 0, 0, 0, 0, 1, 0, '0);
      add("x", 1, 0, 0, 1, 0, 0, 1, F4);
      add(8'h0A, 1, 0, 0, 0, 0, 0, 1, F4);

      #12;
      chk("reset bus", op_bus, '0);
      chk("reset ov", 96'(ops_valid), 0);
      chk("reset err", 96'(err), 0);
      chk("reset idx", 96'(op_idx), 0);
      @(negedge clk) rst = 0;

      foreach (q[i]) begin
         step(q[i].v, q[i].d, q[i].rdy);
         chk($sformatf("v%0d ops_valid", i), 96'(ops_valid), 96'(q[i].ov));
         chk($sformatf("v%0d err", i), 96'(err), 96'(q[i].er));
         chk($sformatf("v%0d drop", i), 96'(drop), 96'(q[i].dr));
         chk($sformatf("v%0d op_idx", i), 96'(op_idx), 96'(q[i].idx));
         if (q[i].cb) chk($sformatf("v%0d op_bus", i), op_bus, q[i].bus);
      end

      // asynchronous reset mid-operand clears everything without a clock edge
      step(1, "1", 0);
      step(1, "2", 0);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("async rst bus", op_bus, '0);
      chk("async rst idx", 96'(op_idx), 0);
      chk("async rst ov", 96'(ops_valid), 0);
      chk("async rst err", 96'(err), 0);
      @(negedge clk) rst = 0;
      step(1, "5", 0);
      step(1, 8'h0D, 0);
      chk("post rst bus", op_bus, 96'h5);
      chk("post rst idx", 96'(op_idx), 1);
      chk("post rst ov", 96'(ops_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
